program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writes the instruction memory that the CPU fetch stage reads. Program bytes arrive from a byte-stream source, such as a UART receiver.
- Holds the CPU in reset while loading. Assembles little-endian 32-bit words and writes them sequentially from word address 0.
- Returns a one-byte status over a valid/ready byte sink, then releases the CPU.
- Sits beside the CPU top, between the serial link and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- ACK_BYTE, 8'hAA, status byte sent after a successful load.
- ERR_BYTE, 8'hEE, status byte sent when the requested length exceeds capacity.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle. No backpressure.
- rx_data  in  8  received byte.
- imem_wren  out  1  instruction memory write enable, one-cycle pulse.
- imem_address  out  ADDR_WIDTH  word address of the write.
- imem_write_data  out  32  assembled instruction word.
- tx_valid  out  1  status byte valid.
- tx_data  out  8  status byte.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- cpu_reset_n  out  1  active-low reset to the CPU; low until the load completes.
- load_done  out  1  high from the RUN state onward.
- load_error  out  1  high in the ERROR state.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values of all outputs: imem_wren=0, imem_address=0, imem_write_data=0, tx_valid=0, tx_data=0, cpu_reset_n=0, load_done=0, load_error=0. State=LEN, byte_cnt=0, word_cnt=0, length=0.
- Wire format: 4 length bytes (N = word count, little-endian), then N words, each 4 bytes little-endian.
- LEN state:
  - Each rx_valid shifts rx_data into length[8*byte_cnt +: 8].
  - After the 4th byte: N==0 -> ACK; N > 2^ADDR_WIDTH -> ERROR; otherwise -> DATA.
  - byte_cnt returns to 0 after the 4th byte.
- DATA state:
  - Bytes fill word[8*byte_cnt +: 8].
  - On the 4th byte, in the next cycle: imem_wren=1, imem_address=word_cnt[ADDR_WIDTH-1:0], imem_write_data=assembled word. Then word_cnt increments.
  - Write latency is 1 cycle after the 4th byte's rx_valid.
  - The write pulse and a new rx_valid in the same cycle are both handled: the new byte goes into the cleared word buffer.
  - When word_cnt reaches N after a write -> ACK.
  - N == 2^ADDR_WIDTH is legal. The last address is 2^ADDR_WIDTH-1, and word_cnt is ADDR_WIDTH+1 bits wide so it does not wrap.
- ACK state:
  - tx_valid=1, tx_data=ACK_BYTE, held stable until tx_ready.
  - On handshake: tx_valid drops the next cycle -> RUN.
- ERROR state:
  - tx_valid=1, tx_data=ERR_BYTE until the handshake, then tx_valid=0.
  - load_error=1 and cpu_reset_n=0 persist until reset. No memory writes occur.
- RUN state: cpu_reset_n=1, load_done=1. rx bytes are ignored; reloading requires reset.
- rx_valid in ACK, RUN or ERROR is ignored.
- rx_data is sampled only when rx_valid=1.
- tx_ready while tx_valid=0 has no effect.
- Reset mid-load: the load is abandoned, the CPU is held in reset, and the machine awaits a new length header. Memory contents are not cleared.
- imem_address and imem_write_data hold their last values when imem_wren=0.

Decomposition:
- Shared package holds:
  - state enum: LEN, DATA, ACK, RUN, ERROR.
  - ACK/ERR byte constants.
  - ROM address width constant reused as the ADDR_WIDTH default.
- Sub-module byte_word_assembler: 2-bit byte counter plus 32-bit little-endian shift-in.
  - Outputs the assembled word and a word_ready pulse.
  - Instantiated once and used for both the length header and the data words.

Test Plan:
- N=1, stream 01 00 00 00 | 13 05 A0 00 -> one imem_wren pulse, addr 0, data 32'h00A00513, 1 cycle after the last byte. Then tx_data=8'hAA, then cpu_reset_n=1 and load_done=1.
- N=3 with back-to-back rx_valid every cycle -> writes at addr 0,1,2 with the correct words, no byte lost across the write/receive overlap.
- Header N=0 -> no writes, ACK 8'hAA, CPU released.
- ADDR_WIDTH=4, N=16 -> 16 writes, the last to addr 15, then ACK. Separately, N=17 -> tx 8'hEE, load_error=1, no writes, cpu_reset_n stays 0.
- tx_ready held 0 for 20 cycles in ACK -> tx_valid and tx_data stay stable; release occurs only after the handshake. Extra rx bytes sent in RUN cause no writes.
- reset asserted after 6 of 8 data bytes (N=2) -> all outputs return to reset values. A fresh N=1 load then succeeds at addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 10;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_ACK,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// Collects four bytes into a little-endian 32-bit word; word_ready flags the
// cycle the fourth byte arrives, with word already including that byte.
module program_loader_byte_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt;
  logic [31:0] buffer;

  always_comb begin
    word = buffer;
    if (byte_valid) word[{byte_cnt, 3'b000} +: 8] = byte_data;
    word_ready = byte_valid && (byte_cnt == 2'd3);
  end

  // Buffer is cleared on completion so the next word starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      buffer   <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      buffer   <= word_ready ? '0 : word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian program into instruction memory while
// holding the CPU in reset, then reports a status byte and releases the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEFAULT,
  parameter logic [7:0] ERR_BYTE   = ERR_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_write_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  load_error,
  output state_t                dbg_state
);

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic [31:0]           length;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   word_cnt_inc;
  logic                  err_sent;
  logic                  asm_valid;
  logic                  asm_ready;
  logic [31:0]           asm_word;

  // rx is a strobe without backpressure; bytes are consumed only while loading.
  assign asm_valid    = rx_valid && (state == ST_LEN || state == ST_DATA);
  assign word_cnt_inc = word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign dbg_state    = state;

  program_loader_byte_word_assembler u_byte_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // tx: tx_valid/tx_data stay stable until tx_valid && tx_ready on a clock
  // edge; the byte is then consumed and tx_valid is low the following cycle.
  always_comb begin
    state_next  = state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    cpu_reset_n = 1'b0;
    load_done   = 1'b0;
    load_error  = 1'b0;
    case (state)
      ST_LEN: begin
        if (asm_ready) begin
          if (asm_word == 32'd0)         state_next = ST_ACK;
          else if (asm_word > CAPACITY)  state_next = ST_ERROR;
          else                           state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (asm_ready && (32'(word_cnt_inc) == length)) state_next = ST_ACK;
      end
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) state_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_reset_n = 1'b1;
        load_done   = 1'b1;
      end
      ST_ERROR: begin
        tx_valid   = !err_sent;
        tx_data    = ERR_BYTE;
        load_error = 1'b1;
      end
      default: state_next = ST_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_LEN;
      length          <= '0;
      word_cnt        <= '0;
      err_sent        <= 1'b0;
      imem_wren       <= 1'b0;
      imem_address    <= '0;
      imem_write_data <= '0;
    end else begin
      state     <= state_next;
      imem_wren <= 1'b0;
      if (state == ST_LEN && asm_ready) length <= asm_word;
      if (state == ST_DATA && asm_ready) begin
        imem_wren       <= 1'b1;
        imem_address    <= word_cnt[ADDR_WIDTH-1:0];
        imem_write_data <= asm_word;
        word_cnt        <= word_cnt_inc;
      end
      if (state == ST_ERROR && tx_ready) err_sent <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader with a 16-word memory: table-driven loads with
// random words and gaps, plus hand-written latency and mid-load reset cases.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW  = 4;
  localparam int CAP = 16;
  localparam int W   = AW + 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          imem_wren;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_write_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          cpu_reset_n;
  logic          load_done;
  logic          load_error;
  state_t        dbg_state;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .imem_wren       (imem_wren),
    .imem_address    (imem_address),
    .imem_write_data (imem_write_data),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .cpu_reset_n     (cpu_reset_n),
    .load_done       (load_done),
    .load_error      (load_error),
    .dbg_state       (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] n;
    int          gap_max;
    int          hold;
    logic [7:0]  exp_status;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  always @(negedge clk) begin
    if (!reset && imem_wren) got_q.push_back({imem_address, imem_write_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    idle(2);
    check("reset_outputs",
          {imem_wren, imem_address, imem_write_data, tx_valid, tx_data,
           cpu_reset_n, load_done, load_error}, '0);
    check("reset_state", dbg_state, ST_LEN);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic finish_status(input logic [7:0] exp_byte, input logic exp_err, input int hold);
    int   waited;
    logic stable;
    waited = 0;
    while (!tx_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("tx_valid_seen", tx_valid, 1'b1);
    if (tx_valid) begin
      check("tx_data", tx_data, exp_byte);
      check("cpu_held", cpu_reset_n, 1'b0);
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!(tx_valid === 1'b1 && tx_data === exp_byte && cpu_reset_n === 1'b0)) stable = 1'b0;
      end
      check("tx_hold_stable", stable, 1'b1);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check("tx_drop", tx_valid, 1'b0);
    end
    idle(1);
    check("status_flags", {cpu_reset_n, load_done, load_error}, exp_err ? 3'b001 : 3'b110);
  endtask

  task automatic compare_writes();
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("write_%0d", i), got_q[i], exp_q[i]);
  endtask

  // Reference: a load of n words succeeds iff n fits the memory, and word i
  // lands at address i; oversize loads write nothing.
  task automatic run_load(input vec_t v);
    logic [31:0] words[$];
    int          nsend;
    exp_q.delete();
    nsend = (v.n > CAP) ? 5 : int'(v.n);
    for (int i = 0; i < nsend; i++) words.push_back($urandom);
    if (v.n <= CAP)
      for (int i = 0; i < nsend; i++) exp_q.push_back({AW'(i), words[i]});
    send_word(v.n, v.gap_max);
    for (int i = 0; i < nsend; i++) send_word(words[i], v.gap_max);
    finish_status(v.exp_status, v.exp_err, v.hold);
    repeat (6) send_byte(8'($urandom));
    idle(2);
    compare_writes();
    check("post_run_flags", {cpu_reset_n, load_done, load_error}, v.exp_err ? 3'b001 : 3'b110);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;

    vecs[0] = '{n: 32'd1,          gap_max: 0, hold: 0,  exp_status: 8'hAA, exp_err: 1'b0};
    vecs[1] = '{n: 32'd3,          gap_max: 0, hold: 3,  exp_status: 8'hAA, exp_err: 1'b0};
    vecs[2] = '{n: 32'd0,          gap_max: 2, hold: 2,  exp_status: 8'hAA, exp_err: 1'b0};
    vecs[3] = '{n: 32'd16,         gap_max: 2, hold: 1,  exp_status: 8'hAA, exp_err: 1'b0};
    vecs[4] = '{n: 32'd17,         gap_max: 1, hold: 4,  exp_status: 8'hEE, exp_err: 1'b1};
    vecs[5] = '{n: 32'd5,          gap_max: 3, hold: 20, exp_status: 8'hAA, exp_err: 1'b0};
    vecs[6] = '{n: 32'h0001_0000,  gap_max: 0, hold: 0,  exp_status: 8'hEE, exp_err: 1'b1};
    vecs[7] = '{n: 32'd9,          gap_max: 4, hold: 5,  exp_status: 8'hAA, exp_err: 1'b0};

    // Single-word load: write must appear one cycle after the last byte.
    do_reset();
    send_word(32'd1, 0);
    send_word(32'h00A00513, 0);
    check("lat_wren", imem_wren, 1'b1);
    check("lat_addr", imem_address, '0);
    check("lat_data", imem_write_data, 32'h00A00513);
    finish_status(8'hAA, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_load(vecs[i]);
    end

    // Abandon a two-word load after six data bytes, then reload one word.
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    send_byte(8'h9A);
    send_byte(8'hBC);
    idle(1);
    check("midload_writes", got_q.size(), 1);
    do_reset();
    run_load('{n: 32'd1, gap_max: 1, hold: 2, exp_status: 8'hAA, exp_err: 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
